// File: rtl/doorlock_pkg.sv
// doorlock_pkg: shared definitions for the door-lock code-entry controller
// and the keypad top that instantiates it.
//   state_t   - controller FSM states (2-bit)
//   BCD_W     - width of one BCD digit
//   NUM_KEYS  - number of digit keys (0..9)
package doorlock_pkg;

    localparam int unsigned BCD_W    = 4;
    localparam int unsigned NUM_KEYS = 10;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_CHECK = 2'd1,
        S_OPEN  = 2'd2,
        S_LOCK  = 2'd3
    } state_t;

endpackage

// File: rtl/doorlock_ctrl_if.sv
// doorlock_ctrl_if: keypad-side bundle of the door-lock controller.
//   key_dig   [9:0] debounced digit key levels, bit i = key i
//   key_ent         debounced enter key level
//   key_clr         debounced clear key level
//   unlock          solenoid drive, high while open
//   alarm           high during lockout
//   err             one-cycle pulse per rejected code
//   digit_cnt [3:0] digits currently buffered
// master: keypad / debounce side; slave: the controller.
interface doorlock_ctrl_if;
    import doorlock_pkg::*;

    logic [NUM_KEYS-1:0] key_dig;
    logic                key_ent;
    logic                key_clr;
    logic                unlock;
    logic                alarm;
    logic                err;
    logic [3:0]          digit_cnt;

    modport master (
        output key_dig, key_ent, key_clr,
        input  unlock, alarm, err, digit_cnt
    );

    modport slave (
        input  key_dig, key_ent, key_clr,
        output unlock, alarm, err, digit_cnt
    );

endinterface

// File: rtl/doorlock_ctrl_rise_edge.sv
// rise_edge: registered rising-edge detector over a W-bit level vector.
//   clk, rst  clock, async active-high reset
//   level     input levels
//   rise      one-cycle pulse, registered, for each 0->1 transition
// The prev register follows the input every cycle regardless of what the
// consumer is doing, so a key held across a state change never yields a
// late edge.
module rise_edge #(
    parameter int unsigned W = 1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [W-1:0] level,
    output logic [W-1:0] rise
);

    logic [W-1:0] prev;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            prev <= '0;
            rise <= '0;
        end else begin
            prev <= level;
            rise <= level & ~prev;
        end
    end

endmodule

// File: rtl/doorlock_ctrl.sv
// doorlock_ctrl: code-entry controller for the door lock.
//   clk, rst  clock, async active-high reset
//   bus       doorlock_ctrl_if.slave: key levels in; unlock, alarm, err,
//             digit_cnt out (all registered)
// Digit key edges are shifted into a BCD buffer; enter compares against
// PASSWORD. A match opens for T_OPEN cycles; MAX_FAIL consecutive misses
// raise alarm for T_LOCKOUT cycles during which all keys are ignored.
module doorlock_ctrl
    import doorlock_pkg::*;
#(
    parameter int unsigned CODE_LEN  = 4,
    parameter logic [31:0] PASSWORD  = 32'h0000_1234,
    parameter int unsigned T_OPEN    = 250_000_000,
    parameter int unsigned MAX_FAIL  = 3,
    parameter int unsigned T_LOCKOUT = 50_000_000 * 30
) (
    input  logic            clk,
    input  logic            rst,
    doorlock_ctrl_if.slave  bus
);

    localparam int unsigned BUF_W = BCD_W * CODE_LEN;
    localparam int unsigned T_MAX = (T_OPEN > T_LOCKOUT) ? T_OPEN : T_LOCKOUT;
    localparam int unsigned TMR_W = (T_MAX > 1) ? $clog2(T_MAX) : 1;

    localparam logic [BUF_W-1:0] CODE      = PASSWORD[BUF_W-1:0];
    localparam logic [TMR_W-1:0] OPEN_LD   = TMR_W'(T_OPEN - 1);
    localparam logic [TMR_W-1:0] LOCK_LD   = TMR_W'(T_LOCKOUT - 1);
    localparam logic [3:0]       FAIL_MAX  = 4'(MAX_FAIL);
    localparam logic [3:0]       CNT_FULL  = 4'(CODE_LEN);

    // ---- key edges: {clr, ent, digits} ----
    logic [NUM_KEYS+1:0] rise;
    logic [NUM_KEYS-1:0] dig_edge;
    logic                ent_edge;
    logic                clr_edge;

    rise_edge #(.W(NUM_KEYS + 2)) u_rise (
        .clk   (clk),
        .rst   (rst),
        .level ({bus.key_clr, bus.key_ent, bus.key_dig}),
        .rise  (rise)
    );

    assign dig_edge = rise[NUM_KEYS-1:0];
    assign ent_edge = rise[NUM_KEYS];
    assign clr_edge = rise[NUM_KEYS+1];

    // exactly one digit edge this cycle; chords are dropped
    logic             dig_one;
    logic [BCD_W-1:0] dig_bcd;

    assign dig_one = (dig_edge != '0) &&
                     ((dig_edge & (dig_edge - NUM_KEYS'(1))) == '0);

    always_comb begin
        dig_bcd = '0;
        for (int i = 0; i < NUM_KEYS; i++)
            if (dig_edge[i]) dig_bcd = BCD_W'(i);
    end

    // ---- FSM ----
    state_t           state, state_n;
    logic [BUF_W-1:0] buffer, buf_n;
    logic [3:0]       cnt, cnt_n;
    logic [3:0]       fail_cnt, fail_n;
    logic [TMR_W-1:0] timer, timer_n;
    logic             unlock_q, alarm_q, err_q;
    logic             err_n;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= S_IDLE;
            buffer   <= '0;
            cnt      <= '0;
            fail_cnt <= '0;
            timer    <= '0;
            unlock_q <= 1'b0;
            alarm_q  <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state    <= state_n;
            buffer   <= buf_n;
            cnt      <= cnt_n;
            fail_cnt <= fail_n;
            timer    <= timer_n;
            // outputs follow the next state so they line up with it
            unlock_q <= (state_n == S_OPEN);
            alarm_q  <= (state_n == S_LOCK);
            err_q    <= err_n;
        end
    end

    always_comb begin
        state_n = state;
        buf_n   = buffer;
        cnt_n   = cnt;
        fail_n  = fail_cnt;
        timer_n = timer;
        err_n   = 1'b0;

        case (state)
            S_IDLE: begin
                if (clr_edge) begin
                    buf_n = '0;
                    cnt_n = '0;
                end else if (ent_edge) begin
                    state_n = S_CHECK;
                end else if (dig_one && (cnt != CNT_FULL)) begin
                    buf_n = (buffer << BCD_W) | BUF_W'(dig_bcd);
                    cnt_n = cnt + 4'd1;
                end
            end

            S_CHECK: begin
                buf_n = '0;
                cnt_n = '0;
                // a short entry never matches, even if the low digits agree
                if ((cnt == CNT_FULL) && (buffer == CODE)) begin
                    fail_n  = '0;
                    timer_n = OPEN_LD;
                    state_n = S_OPEN;
                end else begin
                    err_n  = 1'b1;
                    fail_n = (fail_cnt >= FAIL_MAX) ? FAIL_MAX : fail_cnt + 4'd1;
                    if (fail_n == FAIL_MAX) begin
                        timer_n = LOCK_LD;
                        state_n = S_LOCK;
                    end else begin
                        state_n = S_IDLE;
                    end
                end
            end

            S_OPEN: begin
                if (clr_edge || (timer == '0)) begin
                    timer_n = '0;
                    state_n = S_IDLE;
                end else begin
                    timer_n = timer - TMR_W'(1);
                end
            end

            S_LOCK: begin
                if (timer == '0) begin
                    fail_n  = '0;
                    state_n = S_IDLE;
                end else begin
                    timer_n = timer - TMR_W'(1);
                end
            end

            default: state_n = S_IDLE;
        endcase
    end

    assign bus.unlock    = unlock_q;
    assign bus.alarm     = alarm_q;
    assign bus.err       = err_q;
    assign bus.digit_cnt = cnt;

endmodule

// File: tb/tb_doorlock_ctrl.sv
// tb_doorlock_ctrl: directed plus randomized stimulus against a
// transaction-level model (digit queue, failure count) of the door lock.
// Inputs change and outputs are sampled on the falling clock edge.
module tb_doorlock_ctrl;

    localparam int          CODE_LEN  = 4;
    localparam logic [31:0] PASSWORD  = 32'h0000_1234;
    localparam int          T_OPEN    = 8;
    localparam int          MAX_FAIL  = 3;
    localparam int          T_LOCKOUT = 16;
    localparam int          WIN       = T_LOCKOUT + 8;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    doorlock_ctrl_if bus();

    doorlock_ctrl #(
        .CODE_LEN (CODE_LEN),
        .PASSWORD (PASSWORD),
        .T_OPEN   (T_OPEN),
        .MAX_FAIL (MAX_FAIL),
        .T_LOCKOUT(T_LOCKOUT)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int vec_cnt  = 0;
    int miss_cnt = 0;

    // reference model state
    int m_digits[$];
    int m_fail = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vec_cnt++;
        if (got !== exp) begin
            miss_cnt++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    function automatic int pw_digit(input int i);
        logic [31:0] pw;
        pw = PASSWORD;
        return int'((pw >> (4 * (CODE_LEN - 1 - i))) & 32'hF);
    endfunction

    function automatic logic [9:0] onehot(input int d);
        logic [9:0] v;
        v = '0;
        v[d] = 1'b1;
        return v;
    endfunction

    task automatic press(input int d);
        bus.key_dig = onehot(d);
        tick(); tick();
        if (m_digits.size() < CODE_LEN) m_digits.push_back(d);
        chk("digit_cnt_press", 32'(bus.digit_cnt), 32'(m_digits.size()));
        bus.key_dig = '0;
        tick();
    endtask

    task automatic press_two(input int a, input int b);
        bus.key_dig = onehot(a) | onehot(b);
        tick(); tick();
        chk("digit_cnt_chord", 32'(bus.digit_cnt), 32'(m_digits.size()));
        bus.key_dig = '0;
        tick();
    endtask

    task automatic press_clr(input int d);
        bus.key_clr = 1'b1;
        if (d >= 0) bus.key_dig = onehot(d);
        tick(); tick();
        m_digits.delete();
        chk("digit_cnt_clr", 32'(bus.digit_cnt), 0);
        bus.key_clr = 1'b0;
        bus.key_dig = '0;
        tick();
    endtask

    task automatic press_clr_ent();
        bus.key_clr = 1'b1;
        bus.key_ent = 1'b1;
        tick(); tick(); tick();
        m_digits.delete();
        chk("clr_ent_cnt", 32'(bus.digit_cnt), 0);
        chk("clr_ent_err", 32'(bus.err), 0);
        chk("clr_ent_unlock", 32'(bus.unlock), 0);
        bus.key_clr = 1'b0;
        bus.key_ent = 1'b0;
        tick();
    endtask

    // Enter, then watch a window long enough for a full lockout.
    // clr_at >= 0 relocks manually at that window sample (open only);
    // hold_dig >= 0 holds that digit through the whole open period;
    // lockout windows get random key noise.
    task automatic do_ent(input int clr_at, input int hold_dig);
        bit match, lock;
        int n_unlock, n_alarm, n_err, exp_unlock;
        match = (m_digits.size() == CODE_LEN);
        for (int i = 0; i < m_digits.size(); i++)
            if (m_digits[i] != pw_digit(i)) match = 1'b0;
        lock = 1'b0;
        if (match) begin
            m_fail = 0;
        end else begin
            m_fail++;
            if (m_fail >= MAX_FAIL) begin
                lock   = 1'b1;
                m_fail = 0;
            end
        end
        m_digits.delete();
        if (!match) begin
            clr_at   = -1;
            hold_dig = -1;
        end
        exp_unlock = !match ? 0 : (clr_at >= 0 ? clr_at + 2 : T_OPEN);

        bus.key_ent = 1'b1;
        tick();
        bus.key_ent = 1'b0;
        tick(); tick();
        chk("ent_unlock_lat", 32'(bus.unlock), 32'(match));
        chk("ent_err_lat", 32'(bus.err), 32'(!match));
        chk("ent_alarm_lat", 32'(bus.alarm), 32'(lock));

        n_unlock = 0; n_alarm = 0; n_err = 0;
        for (int s = 0; s < WIN; s++) begin
            n_unlock += int'(bus.unlock);
            n_alarm  += int'(bus.alarm);
            n_err    += int'(bus.err);
            if (hold_dig >= 0 && s == 0) bus.key_dig = onehot(hold_dig);
            if (s == clr_at) bus.key_clr = 1'b1;
            if (s == clr_at + 1) bus.key_clr = 1'b0;
            if (lock && s >= 2 && s <= 10) begin
                bus.key_dig = 10'($urandom);
                bus.key_ent = 1'($urandom);
                bus.key_clr = 1'($urandom);
            end
            if (lock && s == 11) begin
                bus.key_dig = '0;
                bus.key_ent = 1'b0;
                bus.key_clr = 1'b0;
            end
            tick();
        end
        bus.key_dig = '0;
        tick(); tick();
        chk("win_unlock_cycles", 32'(n_unlock), 32'(exp_unlock));
        chk("win_alarm_cycles", 32'(n_alarm), lock ? 32'(T_LOCKOUT) : 0);
        chk("win_err_pulses", 32'(n_err), 32'(!match));
        chk("post_digit_cnt", 32'(bus.digit_cnt), 0);
        chk("post_unlock", 32'(bus.unlock), 0);
        chk("post_alarm", 32'(bus.alarm), 0);
    endtask

    task automatic enter_code(input int d0, input int d1, input int d2, input int d3);
        press(d0); press(d1); press(d2); press(d3);
    endtask

    task automatic do_reset(input string tag);
        rst = 1'b1;
        #1;
        chk({tag, "_unlock"}, 32'(bus.unlock), 0);
        chk({tag, "_alarm"}, 32'(bus.alarm), 0);
        chk({tag, "_err"}, 32'(bus.err), 0);
        chk({tag, "_digit_cnt"}, 32'(bus.digit_cnt), 0);
        m_digits.delete();
        m_fail = 0;
        tick();
        rst = 1'b0;
        tick();
    endtask

    initial begin
        rst         = 1'b1;
        bus.key_dig = '0;
        bus.key_ent = 1'b0;
        bus.key_clr = 1'b0;
        tick(); tick();
        chk("rst_unlock", 32'(bus.unlock), 0);
        chk("rst_alarm", 32'(bus.alarm), 0);
        chk("rst_err", 32'(bus.err), 0);
        chk("rst_digit_cnt", 32'(bus.digit_cnt), 0);
        rst = 1'b0;
        tick();

        // correct code
        enter_code(1, 2, 3, 4);
        do_ent(-1, -1);

        // three wrong codes -> lockout with key noise, then correct code
        for (int k = 0; k < MAX_FAIL; k++) begin
            enter_code(1, 2, 3, 5);
            do_ent(-1, -1);
        end
        enter_code(1, 2, 3, 4);
        do_ent(-1, -1);

        // clear mid-entry, chord ignored
        press(1); press(2); press_clr(-1);
        press(1); press(2);
        press_two(3, 5);
        press(3); press(4);
        do_ent(-1, -1);

        // extra digit discarded; short code rejected
        enter_code(1, 2, 3, 4); press(9);
        do_ent(-1, -1);
        press(1); press(2); press(3);
        do_ent(-1, -1);

        // manual relock; held digit through open
        enter_code(1, 2, 3, 4);
        do_ent(0, -1);
        enter_code(1, 2, 3, 4);
        do_ent(-1, 7);

        // reset mid-open
        enter_code(1, 2, 3, 4);
        bus.key_ent = 1'b1; tick(); bus.key_ent = 1'b0;
        tick(); tick(); tick(); tick();
        chk("mid_open_unlock", 32'(bus.unlock), 1);
        do_reset("rst_open");
        enter_code(1, 2, 3, 4);
        do_ent(-1, -1);

        // reset mid-lock, then failure count must restart from zero
        for (int k = 0; k < MAX_FAIL - 1; k++) begin
            press(8); do_ent(-1, -1);
        end
        press(8);
        bus.key_ent = 1'b1; tick(); bus.key_ent = 1'b0;
        tick(); tick(); tick(); tick();
        chk("mid_lock_alarm", 32'(bus.alarm), 1);
        do_reset("rst_lock");
        for (int k = 0; k < MAX_FAIL - 1; k++) begin
            press(8); do_ent(-1, -1);
        end
        press(1); press(2);
        do_reset("rst_idle");
        press(8); do_ent(-1, -1);

        // randomized entry
        for (int it = 0; it < 120; it++) begin
            int act;
            act = int'($urandom_range(10));
            case (act)
                0, 1, 2, 3, 4: begin
                    if (m_digits.size() < CODE_LEN && $urandom_range(1) == 1)
                        press(pw_digit(m_digits.size()));
                    else
                        press(int'($urandom_range(9)));
                end
                5: begin
                    int a, b;
                    a = int'($urandom_range(9));
                    b = (a + 1 + int'($urandom_range(8))) % 10;
                    press_two(a, b);
                end
                6: press_clr($urandom_range(1) == 1 ? int'($urandom_range(9)) : -1);
                7: press_clr_ent();
                8, 9: do_ent(($urandom_range(3) == 0) ? int'($urandom_range(4)) : -1,
                             ($urandom_range(1) == 1) ? int'($urandom_range(9)) : -1);
                default: begin
                    press_clr(-1);
                    enter_code(1, 2, 3, 4);
                    do_ent(-1, -1);
                end
            endcase
        end

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miss_cnt);
        $finish;
    end

endmodule
